// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_resp_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } resp_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory manager (master) and the responder (slave).
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic                    read_req;
    logic                    write_req;
    logic [31:0]             address_in;
    logic [31:0]             data_in;
    logic [WORD_BYTES-1:0]   byte_en;
    logic                    bus_full;
    logic [31:0]             data_out;
    logic                    ack;
    logic                    err;

    modport master (
        output read_req, write_req, address_in, data_in, byte_en,
        input  bus_full, data_out, ack, err
    );

    modport slave (
        input  read_req, write_req, address_in, data_in, byte_en,
        output bus_full, data_out, ack, err
    );

endinterface

// File: rtl/mem_resp_array.sv
// Word-addressed DEPTH x 32 RAM: byte-lane synchronous write, registered read.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [WORD_BYTES-1:0]    be_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[wr_idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[rd_idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Bus target for the memory manager: fixed-latency read/write of a local RAM with
// address checking. Bus outputs are registered and trail the FSM by one cycle.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [32:0] SPAN     = 33'(DEPTH * WORD_BYTES);

    resp_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [WORD_BYTES-1:0] be_q, be_d;
    op_t                   op_q, op_d;
    logic                  bus_full_q, bus_full_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           dout_q, dout_d;

    logic                  accept;
    logic                  ram_we;
    logic [31:0]           ram_rdata;

    function automatic logic addr_bad(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (off >= SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // The trailing registered outputs keep bus_full high one cycle past RESPOND,
    // so IDLE must also wait for bus_full to drop before accepting.
    assign accept = (state_q == IDLE) && !bus_full_q && (bus.read_req || bus.write_req);

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        op_d    = op_q;
        if (accept) begin
            addr_d  = bus.address_in;
            wdata_d = bus.data_in;
            be_d    = bus.byte_en;
            op_d    = bus.read_req ? OP_READ : OP_WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESPOND;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write commits on the edge entering RESPOND; read data is taken from the
    // registered RAM port on the RESPOND edge, together with ack.
    always_comb begin
        ram_we     = 1'b0;
        bus_full_d = accept || (state_q != IDLE);
        ack_d      = (state_q == RESPOND);
        err_d      = (state_q == RESPOND) && addr_bad(addr_q);
        dout_d     = dout_q;
        if (!rst && (state_d == RESPOND) && (state_q != RESPOND) &&
            (op_d == OP_WRITE) && !addr_bad(addr_d)) begin
            ram_we = 1'b1;
        end
        if ((state_q == RESPOND) && (op_q == OP_READ) && !addr_bad(addr_q)) begin
            dout_d = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_full_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dout_q     <= 32'd0;
        end else begin
            bus_full_q <= bus_full_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        op_q    <= op_d;
    end

    mem_resp_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk      (clk),
        .we_i     (ram_we),
        .wr_idx_i (word_idx(addr_d)),
        .be_i     (be_d),
        .wdata_i  (wdata_d),
        .rd_idx_i (word_idx(addr_d)),
        .rdata_o  (ram_rdata)
    );

    assign bus.bus_full = bus_full_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.data_out = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LATENCY=2, DEPTH=1024, BASE_ADDR=0.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_responder_if bus_if ();

    mem_responder #(
        .DEPTH     (1024),
        .LATENCY   (2),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request, then observe 8 cycles; cycle 0 is the cycle after acceptance.
    task automatic run(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input bit mid_pulse, input logic exp_err, input logic [31:0] exp_dout);
        int          busy;
        int          acks;
        int          ack_at;
        logic        err_seen;
        logic [31:0] dout;
        busy = 0; acks = 0; ack_at = -1; err_seen = 1'b0; dout = 32'hXXXX_XXXX;
        @(negedge clk);
        bus_if.read_req   = rd;
        bus_if.write_req  = wr;
        bus_if.address_in = a;
        bus_if.data_in    = d;
        bus_if.byte_en    = be;
        @(posedge clk);
        #1;
        bus_if.read_req  = 1'b0;
        bus_if.write_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus_if.bus_full) busy++;
            if (bus_if.ack) begin
                acks++;
                ack_at   = k;
                err_seen = bus_if.err;
                dout     = bus_if.data_out;
            end
            if (mid_pulse && k == 1) bus_if.write_req = 1'b1;
            if (mid_pulse && k == 2) bus_if.write_req = 1'b0;
        end
        check({tag, ".busy"},   32'(busy),   32'd4);
        check({tag, ".acks"},   32'(acks),   32'd1);
        check({tag, ".ack_at"}, 32'(ack_at), 32'd3);
        check({tag, ".err"},    32'(err_seen), 32'(exp_err));
        check({tag, ".dout"},   dout,        exp_dout);
    endtask

    initial begin
        int acks_after;
        int busy_after;
        bus_if.read_req   = 1'b0;
        bus_if.write_req  = 1'b0;
        bus_if.address_in = 32'h0;
        bus_if.data_in    = 32'h0;
        bus_if.byte_en    = 4'h0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.bus_full", 32'(bus_if.bus_full), 32'd0);
        check("rst.ack",      32'(bus_if.ack),      32'd0);
        check("rst.err",      32'(bus_if.err),      32'd0);
        check("rst.dout",     bus_if.data_out,      32'h0);

        run("t1.wr",   1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0000_0000);
        run("t1.rd",   1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 32'hDEADBEEF);
        run("t2.wr",   1'b0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, 1'b0, 32'hDEADBEEF);
        run("t2.rd",   1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 32'hDEADBEAA);
        run("t2.wr0",  1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 32'hDEADBEAA);
        run("t2.rd0",  1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 32'hDEADBEAA);
        run("t3.oor",  1'b1, 1'b0, 32'h1000, 32'h0,      4'h0, 1'b0, 1'b1, 32'hDEADBEAA);
        run("t4.mis",  1'b0, 1'b1, 32'h12, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'hDEADBEAA);
        run("t4.rd",   1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 32'hDEADBEAA);
        run("t5.pre",  1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0, 1'b0, 32'hDEADBEAA);
        run("t5.both", 1'b1, 1'b1, 32'h20, 32'h22222222, 4'hF, 1'b1, 1'b0, 32'h11111111);
        run("t5.rd",   1'b1, 1'b0, 32'h20, 32'h0,        4'h0, 1'b0, 1'b0, 32'h11111111);
        run("t6.pre",  1'b0, 1'b1, 32'h30, 32'h30303030, 4'hF, 1'b0, 1'b0, 32'h11111111);

        @(negedge clk);
        bus_if.write_req  = 1'b1;
        bus_if.address_in = 32'h30;
        bus_if.data_in    = 32'hCAFEF00D;
        bus_if.byte_en    = 4'hF;
        @(posedge clk);
        #1 bus_if.write_req = 1'b0;
        @(negedge clk);
        check("t6.busy_before_rst", 32'(bus_if.bus_full), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6.rst.bus_full", 32'(bus_if.bus_full), 32'd0);
        check("t6.rst.ack",      32'(bus_if.ack),      32'd0);
        check("t6.rst.err",      32'(bus_if.err),      32'd0);
        check("t6.rst.dout",     bus_if.data_out,      32'h0);
        acks_after = 0;
        busy_after = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus_if.ack) acks_after++;
            if (bus_if.bus_full) busy_after++;
        end
        check("t6.no_ack_after_rst",  32'(acks_after), 32'd0);
        check("t6.no_busy_after_rst", 32'(busy_after), 32'd0);
        run("t6.rd",   1'b1, 1'b0, 32'h30, 32'h0,        4'h0, 1'b0, 1'b0, 32'h30303030);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
